ibex_prefetch_req_ctrl: RTL and testbench
=========================================

IBEX_PREFETCH_REQ_CTRL -- requirements
Module: ibex_prefetch_req_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2: maximum instruction-bus requests outstanding, matching the fetch FIFO depth minus one.
REQ-002 SHALL have parameter ResetAll, default 1'b0: when 1, datapath registers (address, stored branch target) are also reset.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  fetch enable from the IF stage.
REQ-006 branch_i  input  1  redirect fetch to addr_i this cycle.
REQ-007 addr_i  input  32  branch target, halfword aligned.
REQ-008 fifo_busy_i  input  NUM_REQS  occupancy of the upper FIFO entries.
REQ-009 fifo_clear_o  output  1  FIFO flush, equal to branch_i.
REQ-010 fifo_valid_o / fifo_addr_o[31:0] / fifo_rdata_o[31:0] / fifo_err_o  output  push data to the FIFO.
REQ-011 instr_req_o  output  1  and instr_addr_o  output  32: bus request, word aligned.
REQ-012 instr_gnt_i, instr_rvalid_i, instr_err_i  input  1 each; instr_rdata_i  input  32: bus grant and response.
REQ-013 busy_o  output  1  request pending or any response outstanding.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and WAIT_GNT.
REQ-015 IDLE: instr_req_o = req_i & slot_free, where slot_free = (outstanding_cnt + popcount(fifo_busy_i)) < NUM_REQS.
REQ-016 IDLE -> WAIT_GNT when instr_req_o=1 and instr_gnt_i=0.
REQ-017 WAIT_GNT: instr_req_o=1 and instr_addr_o held stable regardless of req_i, branch_i or slot_free; WAIT_GNT -> IDLE on instr_gnt_i.
REQ-018 IDLE address: instr_addr_o = branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q; a branch with slot_free requests the target in the same cycle.
REQ-019 Branch while in WAIT_GNT: the target is captured in stored_addr_q and the current request is tagged discard; on its grant, fetch_addr_q <- stored target, and the target is requested from the next IDLE cycle.
REQ-020 On every grant, fetch_addr_q <- instr_addr_o + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-021 Outstanding tracking SHALL be an in-order queue of NUM_REQS entries (valid, discard).
  - grant pushes an entry
  - instr_rvalid_i pops the oldest entry
  - push and pop in the same cycle are both applied
REQ-022 branch_i SHALL set discard on all entries present that cycle. A request granted in the branch cycle to the branch target is not discarded.
REQ-023 fifo_valid_o = instr_rvalid_i & ~discard(oldest); fifo_rdata_o = instr_rdata_i; fifo_err_o = instr_err_i; no registering, zero latency.
REQ-024 fifo_clear_o = branch_i; fifo_addr_o = addr_i (unmodified, bit 1 preserved for unaligned targets).
REQ-025 A response arriving in the branch cycle SHALL NOT be forwarded.
REQ-026 A grant and a response in the same cycle SHALL be handled independently; the response belongs to an earlier request.
REQ-027 instr_rvalid_i with no outstanding entry SHALL be ignored, and SHALL be flagged by an assertion.
REQ-028 outstanding_cnt SHALL never exceed NUM_REQS; no request is issued while the queue is full.
REQ-029 busy_o = instr_req_o | any outstanding valid entry.

Reset
REQ-030 On rst_ni=0:
  - FSM -> IDLE
  - all outstanding valid/discard bits = 0
  - instr_req_o=0, fifo_valid_o=0, busy_o=0
REQ-031 fetch_addr_q and stored_addr_q SHALL reset to 0 if ResetAll=1, otherwise be unreset. Fetch is not valid until the first branch_i.
REQ-032 Reset asserted mid-transaction SHALL drop all outstanding tracking; later stray responses are ignored per REQ-027.

Verification
REQ-033 Branch to 0x80 with req_i=1 and gnt held 1 -> requests at 0x80, 0x84, each once; 2 outstanding then stall until rvalid; fifo_valid_o follows each rvalid with the matching data.
REQ-034 Branch to 0x102 -> instr_addr_o=0x100, fifo_addr_o=0x102, fifo_clear_o=1 for one cycle.
REQ-035 Request at 0x200 stalled without gnt, branch to 0x400 -> instr_addr_o stays 0x200 until gnt. Then:
  - next request is 0x400
  - 0x200 response is dropped (fifo_valid_o=0)
  - 0x400 response is forwarded
REQ-036 Two outstanding, branch coinciding with first rvalid -> neither old response forwarded; target response forwarded.
REQ-037 fifo_busy_i=2'b11 with req_i=1 -> instr_req_o=0 until busy drops. fetch_addr_q=0xFFFFFFFC granted -> next instr_addr_o=0x00000000.
REQ-038 rst_ni pulsed low with 2 outstanding -> busy_o=0 immediately; a following rvalid yields fifo_valid_o=0.

Source files
------------

// File: rtl/ibex_prefetch_req_ctrl_if.sv
// Instruction-bus handshake between the prefetch request
// controller and the memory side.
interface ibex_prefetch_req_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ibex_prefetch_req_ctrl.sv
// Prefetch request controller: issues word fetches, tracks
// outstanding responses in order and drops stale ones after branches.
module ibex_prefetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                busy_o,
    ibex_prefetch_req_ctrl_if.master bus
);

    localparam int unsigned CW = $clog2(2 * NUM_REQS + 1);

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_e;

    state_e state_q, state_d;

    logic [NUM_REQS-1:0] valid_q, valid_d;
    logic [NUM_REQS-1:0] disc_q, disc_d;
    logic                pend_q, pend_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         stored_addr_q, stored_addr_d;

    logic [CW-1:0] cnt;
    logic          slot_free;
    logic [31:0]   target;
    logic          grant;
    logic          pop;
    logic          push_disc;
    logic          pushed;

    assign target = {addr_i[31:2], 2'b00};

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cnt = cnt + CW'(valid_q[i]) + CW'(fifo_busy_i[i]);
        end
    end

    assign slot_free = cnt < CW'(NUM_REQS);

    always_comb begin
        state_d  = state_q;
        bus.req  = 1'b0;
        bus.addr = fetch_addr_q;
        unique case (state_q)
            IDLE: begin
                bus.req = req_i & slot_free & rst_ni;
                if (branch_i) begin
                    bus.addr = target;
                end
                if (bus.req && !bus.gnt) begin
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                bus.req = 1'b1;
                if (bus.gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant     = bus.req & bus.gnt;
    assign pop       = bus.rvalid & valid_q[0];
    // The request in flight when a branch arrives fetches a stale line.
    assign push_disc = (state_q == WAIT_GNT) & (pend_q | branch_i);

    always_comb begin
        pend_d        = pend_q;
        stored_addr_d = stored_addr_q;
        fetch_addr_d  = fetch_addr_q;
        if (state_q == WAIT_GNT && branch_i) begin
            stored_addr_d = target;
        end
        if (grant) begin
            pend_d = 1'b0;
            if (push_disc) begin
                fetch_addr_d = branch_i ? target : stored_addr_q;
            end else begin
                fetch_addr_d = bus.addr + 32'd4;
            end
        end else if (branch_i) begin
            if (state_q == WAIT_GNT) begin
                pend_d = 1'b1;
            end else begin
                fetch_addr_d = target;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        disc_d  = disc_q | (branch_i ? valid_q : '0);
        pushed  = 1'b0;
        if (pop) begin
            for (int i = 0; i < NUM_REQS - 1; i++) begin
                valid_d[i] = valid_d[i+1];
                disc_d[i]  = disc_d[i+1];
            end
            valid_d[NUM_REQS-1] = 1'b0;
            disc_d[NUM_REQS-1]  = 1'b0;
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant && !pushed && !valid_d[i]) begin
                valid_d[i] = 1'b1;
                disc_d[i]  = push_disc;
                pushed     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= '0;
            disc_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            disc_q  <= disc_d;
            pend_q  <= pend_d;
        end
    end

    if (ResetAll) begin : g_addr_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fetch_addr_q  <= '0;
                stored_addr_q <= '0;
            end else begin
                fetch_addr_q  <= fetch_addr_d;
                stored_addr_q <= stored_addr_d;
            end
        end
    end else begin : g_addr_nr
        always_ff @(posedge clk_i) begin
            fetch_addr_q  <= fetch_addr_d;
            stored_addr_q <= stored_addr_d;
        end
    end

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_rdata_o = bus.rdata;
    assign fifo_err_o   = bus.err;
    assign fifo_valid_o = pop & ~disc_q[0] & ~branch_i;
    assign busy_o       = bus.req | (|valid_q);

    stray_rvalid: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.rvalid |-> valid_q[0]
    ) else $warning("stray instr rvalid with no outstanding request");

endmodule

// File: tb/tb_ibex_prefetch_req_ctrl.sv
// Directed bench for the prefetch request controller.
// Inputs change 1ns after the rising edge; outputs sampled 3ns later.
module tb_ibex_prefetch_req_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic [1:0]  fifo_busy_i;
    logic        fifo_clear_o;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    ibex_prefetch_req_ctrl_if bus ();

    ibex_prefetch_req_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .branch_i     (branch_i),
        .addr_i       (addr_i),
        .fifo_busy_i  (fifo_busy_i),
        .fifo_clear_o (fifo_clear_o),
        .fifo_valid_o (fifo_valid_o),
        .fifo_addr_o  (fifo_addr_o),
        .fifo_rdata_o (fifo_rdata_o),
        .fifo_err_o   (fifo_err_o),
        .busy_o       (busy_o),
        .bus          (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic rq, input logic br,
                       input logic [31:0] a, input logic g,
                       input logic rv, input logic [31:0] rd);
        req_i      = rq;
        branch_i   = br;
        addr_i     = a;
        bus.gnt    = g;
        bus.rvalid = rv;
        bus.rdata  = rd;
        #3;
    endtask

    initial begin
        rst_ni      = 1'b0;
        fifo_busy_i = 2'b00;
        bus.err     = 1'b0;
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_fvalid", fifo_valid_o, 1'b0);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Branch to 0x80 with grant held high
        drv(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
        chk("a_req0", bus.req, 1'b1);
        chk("a_addr0", bus.addr, 32'h80);
        chk("a_clr0", fifo_clear_o, 1'b1);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("a_req1", bus.req, 1'b1);
        chk("a_addr1", bus.addr, 32'h84);
        chk("a_clr1", fifo_clear_o, 1'b0);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("a_full_req", bus.req, 1'b0);
        chk("a_full_busy", busy_o, 1'b1);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_1111);
        chk("a_full_req2", bus.req, 1'b0);
        chk("a_rv0", fifo_valid_o, 1'b1);
        chk("a_rd0", fifo_rdata_o, 32'h1111_1111);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2222_2222);
        chk("a_req2", bus.req, 1'b1);
        chk("a_addr2", bus.addr, 32'h88);
        chk("a_rv1", fifo_valid_o, 1'b1);
        chk("a_rd1", fifo_rdata_o, 32'h2222_2222);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_3333);
        chk("a_rv2", fifo_valid_o, 1'b1);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("a_idle_busy", busy_o, 1'b0);
        cyc();

        // Unaligned branch target
        drv(1'b1, 1'b1, 32'h102, 1'b1, 1'b0, 32'h0);
        chk("b_addr", bus.addr, 32'h100);
        chk("b_faddr", fifo_addr_o, 32'h102);
        chk("b_clr", fifo_clear_o, 1'b1);
        cyc();
        bus.err = 1'b1;
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hABCD_0000);
        chk("b_clr_off", fifo_clear_o, 1'b0);
        chk("b_rv", fifo_valid_o, 1'b1);
        chk("b_err", fifo_err_o, 1'b1);
        cyc();
        bus.err = 1'b0;

        // Branch while stalled waiting for grant
        drv(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        chk("c_addr0", bus.addr, 32'h200);
        cyc();
        drv(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        chk("c_hold_br", bus.addr, 32'h200);
        chk("c_req_br", bus.req, 1'b1);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("c_hold", bus.addr, 32'h200);
        chk("c_req_hold", bus.req, 1'b1);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("c_gnt_addr", bus.addr, 32'h200);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("c_tgt_req", bus.req, 1'b1);
        chk("c_tgt_addr", bus.addr, 32'h400);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000_0000);
        chk("c_drop", fifo_valid_o, 1'b0);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_0000);
        chk("c_fwd", fifo_valid_o, 1'b1);
        chk("c_fwd_rd", fifo_rdata_o, 32'h4000_0000);
        cyc();

        // Branch coinciding with a response, two outstanding
        drv(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("d_addr1", bus.addr, 32'h504);
        cyc();
        drv(1'b1, 1'b1, 32'h600, 1'b1, 1'b1, 32'h5000_0000);
        chk("d_br_rv", fifo_valid_o, 1'b0);
        chk("d_full", bus.req, 1'b0);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("d_tgt_addr", bus.addr, 32'h600);
        chk("d_tgt_req", bus.req, 1'b1);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5040_0000);
        chk("d_old_drop", fifo_valid_o, 1'b0);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6000_0000);
        chk("d_tgt_fwd", fifo_valid_o, 1'b1);
        cyc();

        // FIFO occupancy back-pressure
        fifo_busy_i = 2'b11;
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("e_busy11", bus.req, 1'b0);
        cyc();
        fifo_busy_i = 2'b10;
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("e_busy10", bus.req, 1'b1);
        chk("e_addr", bus.addr, 32'h604);
        cyc();
        fifo_busy_i = 2'b00;
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6040_0000);
        chk("e_rv", fifo_valid_o, 1'b1);
        cyc();

        // Address wrap at the top of memory
        drv(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
        chk("f_addr", bus.addr, 32'hFFFF_FFFC);
        chk("f_faddr", fifo_addr_o, 32'hFFFF_FFFE);
        cyc();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("f_wrap", bus.addr, 32'h0000_0000);
        chk("f_wrap_req", bus.req, 1'b1);
        cyc();

        // Reset pulse with two outstanding
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("g_pre_busy", busy_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("g_rst_busy", busy_o, 1'b0);
        chk("g_rst_req", bus.req, 1'b0);
        cyc();
        rst_ni = 1'b1;
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("g_stray", fifo_valid_o, 1'b0);
        chk("g_stray_busy", busy_o, 1'b0);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
